// File: rtl/spi_ram_arbiter_if.sv
`default_nettype none
// ============================================================================
//  spi_ram_arbiter_if : request/response ports and SPI pins of spi_ram_arbiter
//  Revision: 1.0
// ============================================================================
interface spi_ram_arbiter_if;
   logic        fetch_req;
   logic [23:0] fetch_addr;
   logic [15:0] fetch_rdata;
   logic        fetch_ack;
   logic        data_req;
   logic        data_we;
   logic [23:0] data_addr;
   logic [15:0] data_wdata;
   logic [15:0] data_rdata;
   logic        data_ack;
   logic        busy;
   logic        spi_select;
   logic        spi_clk;
   logic        spi_mosi;
   logic        spi_miso;

   modport slave (
      input  fetch_req, fetch_addr, data_req, data_we, data_addr, data_wdata, spi_miso,
      output fetch_rdata, fetch_ack, data_rdata, data_ack, busy, spi_select, spi_clk, spi_mosi
   );

   modport master (
      output fetch_req, fetch_addr, data_req, data_we, data_addr, data_wdata, spi_miso,
      input  fetch_rdata, fetch_ack, data_rdata, data_ack, busy, spi_select, spi_clk, spi_mosi
   );
endinterface
`default_nettype wire

// File: rtl/spi_ram_arbiter.sv
`default_nettype none
// ============================================================================
//  spi_ram_arbiter : round-robin fetch/data arbiter driving one SPI SRAM bus
//  Revision: 1.0
// ============================================================================
module spi_ram_arbiter (
   input  logic              clk,
   input  logic              rst,
   spi_ram_arbiter_if.slave  bus_io
);
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam logic [7:0] CMD_READ  = 8'h03;
   localparam logic [7:0] CMD_WRITE = 8'h02;

   state_t      state_q, state_d;
   logic [47:0] shift_q, shift_d;
   logic [5:0]  idx_q, idx_d;
   logic        phase_q, phase_d;
   logic        rd_q, rd_d;
   // Port of the transaction in flight; doubles as the round-robin pointer.
   logic        gnt_data_q, gnt_data_d;
   logic [14:0] rx_q, rx_d;
   logic [15:0] fetch_rdata_q, fetch_rdata_d;
   logic [15:0] data_rdata_q, data_rdata_d;
   logic        pick_data;
   logic [15:0] rx_next;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         shift_q       <= '0;
         idx_q         <= '0;
         phase_q       <= 1'b0;
         rd_q          <= 1'b0;
         gnt_data_q    <= 1'b0;
         rx_q          <= '0;
         fetch_rdata_q <= '0;
         data_rdata_q  <= '0;
      end else begin
         state_q       <= state_d;
         shift_q       <= shift_d;
         idx_q         <= idx_d;
         phase_q       <= phase_d;
         rd_q          <= rd_d;
         gnt_data_q    <= gnt_data_d;
         rx_q          <= rx_d;
         fetch_rdata_q <= fetch_rdata_d;
         data_rdata_q  <= data_rdata_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      shift_d       = shift_q;
      idx_d         = idx_q;
      phase_d       = phase_q;
      rd_d          = rd_q;
      gnt_data_d    = gnt_data_q;
      rx_d          = rx_q;
      fetch_rdata_d = fetch_rdata_q;
      data_rdata_d  = data_rdata_q;
      pick_data     = bus_io.data_req && (!bus_io.fetch_req || !gnt_data_q);
      rx_next       = {rx_q, bus_io.spi_miso};

      case (state_q)
         IDLE: begin
            if (bus_io.fetch_req || bus_io.data_req) begin
               gnt_data_d = pick_data;
               if (pick_data) begin
                  rd_d    = !bus_io.data_we;
                  shift_d = {bus_io.data_we ? CMD_WRITE : CMD_READ, bus_io.data_addr,
                             bus_io.data_we ? bus_io.data_wdata : 16'h0000};
               end else begin
                  rd_d    = 1'b1;
                  shift_d = {CMD_READ, bus_io.fetch_addr, 16'h0000};
               end
               idx_d   = 6'd47;
               phase_d = 1'b0;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            if (!phase_q) begin
               phase_d = 1'b1;
            end else begin
               phase_d = 1'b0;
               shift_d = {shift_q[46:0], 1'b0};
               if (rd_q && (idx_q <= 6'd15)) begin
                  rx_d = rx_next[14:0];
               end
               if (idx_q == 6'd0) begin
                  state_d = DONE;
                  // Final bit goes straight into rdata so it is visible during DONE.
                  if (rd_q) begin
                     if (gnt_data_q) begin
                        data_rdata_d = rx_next;
                     end else begin
                        fetch_rdata_d = rx_next;
                     end
                  end
               end else begin
                  idx_d = idx_q - 6'd1;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign bus_io.spi_select  = (state_q != SHIFT);
   assign bus_io.spi_clk     = (state_q == SHIFT) && phase_q;
   assign bus_io.spi_mosi    = (state_q == SHIFT) && shift_q[47];
   assign bus_io.busy        = (state_q != IDLE);
   assign bus_io.fetch_ack   = (state_q == DONE) && !gnt_data_q;
   assign bus_io.data_ack    = (state_q == DONE) && gnt_data_q;
   assign bus_io.fetch_rdata = fetch_rdata_q;
   assign bus_io.data_rdata  = data_rdata_q;
endmodule
`default_nettype wire
